// File: rtl/prio_arbiter_rr_if.sv
// Bus between the requesters and prio_arbiter_rr.
//   master : requester side, drives req/mode/en/done and observes the grant
//   slave  : arbiter side, samples the requests and drives the grant outputs
// Signals:
//   req[N-1:0]        request vector, bit i = requester i
//   mode              0 = fixed priority (highest index wins), 1 = round-robin
//   en                arbitration enable; gates new grants only
//   done              single-cycle release from the current owner
//   gnt_valid         a grant is active
//   gnt_idx[W-1:0]    index of the granted requester
//   gnt_onehot[N-1:0] one-hot of the granted requester
//   timeout           one-cycle pulse when a grant is revoked by timeout
//   busy              arbiter holds a grant (same as gnt_valid)
interface prio_arbiter_rr_if #(
    parameter int N = 8
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] req;
    logic         mode;
    logic         en;
    logic         done;
    logic         gnt_valid;
    logic [W-1:0] gnt_idx;
    logic [N-1:0] gnt_onehot;
    logic         timeout;
    logic         busy;

    modport master (
        output req, mode, en, done,
        input  gnt_valid, gnt_idx, gnt_onehot, timeout, busy
    );

    modport slave (
        input  req, mode, en, done,
        output gnt_valid, gnt_idx, gnt_onehot, timeout, busy
    );
endinterface

// File: rtl/prio_arbiter_rr.sv
// Registered N-way arbiter with fixed-priority or round-robin selection.
// A winner is granted one cycle after its request is sampled and holds the
// grant until it signals done, drops its request, or the hold timer expires.
// Every release is followed by one idle cycle before the next grant.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    prio_arbiter_rr_if.slave (requests in, grant out)
//
// state | meaning
// IDLE  | no grant; arbitrate when en=1 and any request is set
// GRANT | grant held for gnt_idx; hold counter running
module prio_arbiter_rr #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input logic              clk,
    input logic              rst_n,
    prio_arbiter_rr_if.slave bus
);
    localparam int W  = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [W-1:0]  IDX_LAST  = W'(N - 1);
    localparam logic [W:0]    N_EXT     = (W + 1)'(N);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  idx_q, idx_d;
    logic [N-1:0]  oh_q, oh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  ptr_q, ptr_d;
    logic          mode_q, mode_d;
    logic          timeout_q, timeout_d;

    logic [W-1:0]   fixed_win;
    logic [W-1:0]   rr_win;
    logic [W-1:0]   rr_off;
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [W:0]     rr_sum;
    logic           release_ev;
    logic           expire_ev;

    // Fixed priority: the highest set index wins.
    always_comb begin
        fixed_win = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.req[i]) fixed_win = W'(i);
        end
    end

    // Round-robin: rotate req so ptr lands on bit 0, take the lowest set bit,
    // then add ptr back modulo N.
    always_comb begin
        req_dbl = {bus.req, bus.req};
        req_rot = N'(req_dbl >> ptr_q);
        rr_off  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) rr_off = W'(k);
        end
        rr_sum = {1'b0, ptr_q} + {1'b0, rr_off};
        rr_win = (rr_sum >= N_EXT) ? W'(rr_sum - N_EXT) : W'(rr_sum);
    end

    assign release_ev = bus.done || !bus.req[idx_q];
    assign expire_ev  = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        oh_d      = oh_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        mode_d    = mode_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en && (|bus.req)) begin
                    state_d = GRANT;
                    idx_d   = bus.mode ? rr_win : fixed_win;
                    oh_d    = '0;
                    oh_d[bus.mode ? rr_win : fixed_win] = 1'b1;
                    cnt_d   = '0;
                    mode_d  = bus.mode;
                end
            end
            GRANT: begin
                if (release_ev || expire_ev) begin
                    state_d   = IDLE;
                    idx_d     = '0;
                    oh_d      = '0;
                    cnt_d     = '0;
                    // A release in the same cycle as expiry wins; no pulse.
                    timeout_d = expire_ev && !release_ev;
                    // Pointer follows the mode this grant was made in.
                    if (mode_q) ptr_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            oh_q      <= '0;
            cnt_q     <= '0;
            ptr_q     <= '0;
            mode_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            oh_q      <= oh_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            mode_q    <= mode_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.gnt_valid  = (state_q == GRANT);
    assign bus.busy       = (state_q == GRANT);
    assign bus.gnt_idx    = idx_q;
    assign bus.gnt_onehot = oh_q;
    assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_prio_arbiter_rr.sv
module tb_prio_arbiter_rr;
    localparam int N = 8;
    localparam int W = 3;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   exp_q[$];
    int   e;

    prio_arbiter_rr_if #(.N(N)) bus();

    prio_arbiter_rr #(.N(N), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_checks++; if (bus.gnt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", bus.gnt_valid); end
        n_checks++; if (bus.gnt_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", bus.gnt_idx); end
        n_checks++; if (bus.gnt_onehot !== 8'h00) begin n_fail++; $display("FAIL reset_onehot got %h want 00", bus.gnt_onehot); end
        n_checks++; if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %0b want 0", bus.timeout); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_fixed();
        logic [7:0] pats [4];
        int         exps [4];
        pats = '{8'h00, 8'h05, 8'h18, 8'h80};
        exps = '{-1, 2, 4, 7};
        bus.mode = 1'b0;
        bus.en   = 1'b1;
        for (int p = 0; p < 4; p++) begin
            bus.req = pats[p];
            if (exps[p] >= 0) exp_q.push_back(exps[p]);
            step();
            if (exps[p] < 0) begin
                n_checks++; if (bus.gnt_valid !== 1'b0) begin n_fail++; $display("FAIL fixed_nogrant got %0b want 0", bus.gnt_valid); end
            end else begin
                n_checks++; if (bus.gnt_valid !== 1'b1) begin n_fail++; $display("FAIL fixed_latency req=%h got valid %0b want 1", pats[p], bus.gnt_valid); end
                e = exp_q.pop_front();
                n_checks++; if (bus.gnt_idx !== W'(e)) begin n_fail++; $display("FAIL fixed_idx req=%h got %0d want %0d", pats[p], bus.gnt_idx, e); end
                n_checks++; if (bus.gnt_onehot !== (8'd1 << e)) begin n_fail++; $display("FAIL fixed_onehot req=%h got %h want %h", pats[p], bus.gnt_onehot, 8'd1 << e); end
                bus.done = 1'b1;
                step();
                bus.done = 1'b0;
                bus.req  = 8'h00;
                n_checks++; if (bus.gnt_valid !== 1'b0) begin n_fail++; $display("FAIL fixed_release got %0b want 0", bus.gnt_valid); end
            end
        end
    endtask

    task automatic test_rr_wrap();
        bus.mode = 1'b1;
        bus.req  = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            exp_q.push_back(k % N);
            step();
            n_checks++; if (bus.gnt_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid step %0d got %0b want 1", k, bus.gnt_valid); end
            e = exp_q.pop_front();
            n_checks++; if (bus.gnt_idx !== W'(e)) begin n_fail++; $display("FAIL rr_idx step %0d got %0d want %0d", k, bus.gnt_idx, e); end
            n_checks++; if (bus.gnt_onehot !== (8'd1 << e)) begin n_fail++; $display("FAIL rr_onehot step %0d got %h want %h", k, bus.gnt_onehot, 8'd1 << e); end
            bus.done = 1'b1;
            step();
            bus.done = 1'b0;
            n_checks++; if (bus.gnt_valid !== 1'b0) begin n_fail++; $display("FAIL rr_gap step %0d got %0b want 0", k, bus.gnt_valid); end
        end
        bus.req = 8'h00;
        step();
    endtask

    task automatic test_timeout();
        bus.mode = 1'b0;
        bus.req  = 8'h02;
        exp_q.push_back(1);
        step();
        n_checks++; if (bus.gnt_valid !== 1'b1) begin n_fail++; $display("FAIL to_grant got %0b want 1", bus.gnt_valid); end
        e = exp_q.pop_front();
        n_checks++; if (bus.gnt_idx !== W'(e)) begin n_fail++; $display("FAIL to_idx got %0d want %0d", bus.gnt_idx, e); end
        for (int i = 1; i < 4; i++) begin
            step();
            n_checks++; if (bus.gnt_valid !== 1'b1 || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL to_hold cycle %0d got valid %0b timeout %0b want 1 0", i, bus.gnt_valid, bus.timeout); end
        end
        step();
        n_checks++; if (bus.gnt_valid !== 1'b0) begin n_fail++; $display("FAIL to_drop got valid %0b want 0", bus.gnt_valid); end
        n_checks++; if (bus.timeout !== 1'b1) begin n_fail++; $display("FAIL to_pulse got %0b want 1", bus.timeout); end
        n_checks++; if (bus.gnt_onehot !== 8'h00) begin n_fail++; $display("FAIL to_onehot_idle got %h want 00", bus.gnt_onehot); end
        exp_q.push_back(1);
        step();
        n_checks++; if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL to_pulse_width got %0b want 0", bus.timeout); end
        n_checks++; if (bus.gnt_valid !== 1'b1) begin n_fail++; $display("FAIL to_regrant got %0b want 1", bus.gnt_valid); end
        e = exp_q.pop_front();
        n_checks++; if (bus.gnt_idx !== W'(e)) begin n_fail++; $display("FAIL to_regrant_idx got %0d want %0d", bus.gnt_idx, e); end
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.req  = 8'h00;
        step();
    endtask

    task automatic test_drop_simul();
        bus.mode = 1'b1;
        bus.req  = 8'h08;
        exp_q.push_back(3);
        step();
        e = exp_q.pop_front();
        n_checks++; if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== W'(e)) begin n_fail++; $display("FAIL drop_grant got valid %0b idx %0d want 1 %0d", bus.gnt_valid, bus.gnt_idx, e); end
        bus.req  = 8'h00;
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        n_checks++; if (bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL drop_release got valid %0b timeout %0b want 0 0", bus.gnt_valid, bus.timeout); end
        step();
        n_checks++; if (bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL drop_single got valid %0b timeout %0b want 0 0", bus.gnt_valid, bus.timeout); end
        bus.req = 8'hFF;
        exp_q.push_back(4);
        step();
        e = exp_q.pop_front();
        n_checks++; if (bus.gnt_idx !== W'(e) || bus.gnt_valid !== 1'b1) begin n_fail++; $display("FAIL drop_ptr got valid %0b idx %0d want 1 %0d", bus.gnt_valid, bus.gnt_idx, e); end
        bus.mode = 1'b0;
        bus.en   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++; if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 3'd4 || bus.gnt_onehot !== 8'h10) begin n_fail++; $display("FAIL drop_stable got valid %0b idx %0d oh %h want 1 4 10", bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot); end
        end
        bus.done = 1'b1;
        bus.en   = 1'b1;
        step();
        bus.done = 1'b0;
        bus.mode = 1'b1;
        n_checks++; if (bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL drop_done got valid %0b timeout %0b want 0 0", bus.gnt_valid, bus.timeout); end
    endtask

    task automatic test_reset_mid();
        bus.req = 8'hFF;
        exp_q.push_back(5);
        step();
        e = exp_q.pop_front();
        n_checks++; if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== W'(e)) begin n_fail++; $display("FAIL rstmid_grant got valid %0b idx %0d want 1 %0d", bus.gnt_valid, bus.gnt_idx, e); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_checks++; if (bus.gnt_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got valid %0b busy %0b want 0 0", bus.gnt_valid, bus.busy); end
        n_checks++; if (bus.gnt_idx !== 3'd0 || bus.gnt_onehot !== 8'h00) begin n_fail++; $display("FAIL rstmid_idx got idx %0d oh %h want 0 00", bus.gnt_idx, bus.gnt_onehot); end
        n_checks++; if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL rstmid_timeout got %0b want 0", bus.timeout); end
        exp_q.push_back(0);
        step();
        e = exp_q.pop_front();
        n_checks++; if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== W'(e)) begin n_fail++; $display("FAIL rstmid_ptr got valid %0b idx %0d want 1 %0d", bus.gnt_valid, bus.gnt_idx, e); end
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.req  = 8'h00;
        step();
    endtask

    task automatic test_enable();
        bus.en  = 1'b0;
        bus.req = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (bus.gnt_valid !== 1'b0) begin n_fail++; $display("FAIL en_gate cycle %0d got %0b want 0", i, bus.gnt_valid); end
        end
        bus.en = 1'b1;
        exp_q.push_back(1);
        step();
        n_checks++; if (bus.gnt_valid !== 1'b1) begin n_fail++; $display("FAIL en_latency got %0b want 1", bus.gnt_valid); end
        e = exp_q.pop_front();
        n_checks++; if (bus.gnt_idx !== W'(e) || bus.gnt_onehot !== (8'd1 << e)) begin n_fail++; $display("FAIL en_idx got idx %0d oh %h want %0d %h", bus.gnt_idx, bus.gnt_onehot, e, 8'd1 << e); end
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.req  = 8'h00;
        step();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left got %0d entries want 0", exp_q.size()); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.mode = 1'b0;
        bus.en   = 1'b0;
        bus.done = 1'b0;
        test_reset();
        test_fixed();
        test_rr_wrap();
        test_timeout();
        test_drop_simul();
        test_reset_mid();
        test_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
